// File: rtl/gate_vector_seq.sv
// Stimulus/check stage for a 3-input combinational gate: walks all 8 input
// patterns, samples the gate after a programmable hold and scores each pattern.
module gate_vector_seq #(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       dut_out,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [7:0] err_vec
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state;
  logic [2:0] sel;
  logic [2:0] idx;
  logic [7:0] hcnt;
  logic       expected;
  logic       sel_ok;
  logic       miss;

  // Expected gate response for the latched function at the current pattern.
  always_comb begin
    expected = 1'b0;
    case (sel)
      3'b000:  expected = &idx;
      3'b001:  expected = ~&idx;
      3'b010:  expected = |idx;
      3'b011:  expected = ~|idx;
      3'b100:  expected = ^idx;
      3'b101:  expected = ~^idx;
      default: expected = 1'b0;
    endcase
  end

  assign sel_ok = (gate_sel[2:1] != 2'b11);
  assign miss   = (dut_out != expected);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      idx     <= '0;
      hcnt    <= '0;
      a       <= 1'b0;
      b       <= 1'b0;
      c       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
      err_vec <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sel       <= gate_sel;
            idx       <= '0;
            hcnt      <= '0;
            {a, b, c} <= '0;
            pass      <= 1'b0;
            if (sel_ok) begin
              state   <= APPLY;
              busy    <= 1'b1;
              done    <= 1'b0;
              err_cnt <= '0;
              err_vec <= '0;
            end else begin
              // Reserved function code: report every pattern as failed at once.
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              err_cnt <= 4'd8;
              err_vec <= '1;
            end
          end
        end
        APPLY: begin
          if (hcnt == HOLD_LAST) begin
            hcnt <= '0;
            if (miss) begin
              err_vec[idx] <= 1'b1;
              err_cnt      <= err_cnt + 4'd1;
            end
            if (idx == 3'd7) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              {a, b, c} <= '0;
              // Include the final pattern's result, which lands on this same edge.
              pass      <= (err_cnt == 4'd0) && !miss;
            end else begin
              idx       <= idx + 3'd1;
              {a, b, c} <= idx + 3'd1;
            end
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_seq.sv
// Bench for gate_vector_seq: table of runs with a scoreboard queue of expected
// results, plus reset, start-while-busy and single-cycle-hold sequences.
module tb_gate_vector_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] gate_sel;
  logic       dout;
  logic       a, b, c, busy, done, pass;
  logic [3:0] err_cnt;
  logic [7:0] err_vec;

  logic       start1;
  logic [2:0] gate_sel1;
  logic       dout1;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [3:0] err_cnt1;
  logic [7:0] err_vec1;

  int         checks = 0;
  int         errors = 0;
  int         mode;
  logic [2:0] run_sel;
  logic [12:0] exp_q[$];

  typedef struct {
    logic [2:0] sel;
    int         mode;   // 0 tie0, 1 tie1, 2 correct gate, 3 AND gate
    logic [7:0] ev;
    logic [3:0] ec;
    logic       ep;
    int         poke;   // busy cycle at which a stray start is pulsed, -1 none
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  gate_vector_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_sel(gate_sel), .dut_out(dout),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .err_vec(err_vec)
  );

  gate_vector_seq #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .gate_sel(gate_sel1), .dut_out(dout1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err_cnt1), .err_vec(err_vec1)
  );

  function automatic logic gate_f(input logic [2:0] s, input logic [2:0] p);
    case (s)
      3'b000:  return p[2] & p[1] & p[0];
      3'b001:  return !(p[2] & p[1] & p[0]);
      3'b010:  return p[2] | p[1] | p[0];
      3'b011:  return !(p[2] | p[1] | p[0]);
      3'b100:  return p[2] ^ p[1] ^ p[0];
      3'b101:  return !(p[2] ^ p[1] ^ p[0]);
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    dout = 1'b0;
    case (mode)
      0:       dout = 1'b0;
      1:       dout = 1'b1;
      3:       dout = a & b & c;
      default: dout = gate_f(run_sel, {a, b, c});
    endcase
  end

  assign dout1 = a1 ^ b1 ^ c1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int nbusy;
    int pat_bad;
    int cyc;
    logic [12:0] e;
    exp_q.push_back({v.ev, v.ec, v.ep});
    run_sel  = v.sel;
    mode     = v.mode;
    gate_sel = v.sel;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    gate_sel = ~v.sel;  // must not disturb the run in progress
    nbusy = 0; pat_bad = 0; cyc = 0;
    while (!done && cyc < 200) begin
      if (busy) begin
        if (nbusy == 0)
          check("cleared_at_start", {err_vec, err_cnt}, 12'h000);
        if ({a, b, c} != 3'(nbusy / 10)) pat_bad++;
        nbusy++;
      end
      start = (cyc == v.poke);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    check("busy_cycles", nbusy, (v.sel[2:1] == 2'b11) ? 0 : 80);
    check("pattern_hold", pat_bad, 0);
    check("abc_idle_in_done", {29'd0, a, b, c}, 32'd0);
    e = exp_q.pop_front();
    check("result", {err_vec, err_cnt, pass}, e);
  endtask

  initial begin
    tbl[0] = '{3'b001, 2, 8'h00, 4'd0, 1'b1, 25};
    tbl[1] = '{3'b000, 0, 8'h80, 4'd1, 1'b0, -1};
    tbl[2] = '{3'b001, 0, 8'h7F, 4'd7, 1'b0, -1};
    tbl[3] = '{3'b101, 2, 8'h00, 4'd0, 1'b1, -1};
    tbl[4] = '{3'b110, 2, 8'hFF, 4'd8, 1'b0, -1};
    tbl[5] = '{3'b010, 1, 8'h01, 4'd1, 1'b0, -1};
    tbl[6] = '{3'b011, 1, 8'hFE, 4'd7, 1'b0, 40};
    tbl[7] = '{3'b111, 2, 8'hFF, 4'd8, 1'b0, -1};
    tbl[8] = '{3'b100, 3, 8'h16, 4'd3, 1'b0, -1};
    tbl[9] = '{3'b000, 2, 8'h00, 4'd0, 1'b1, -1};

    rst_n = 1'b0; start = 1'b0; gate_sel = '0; mode = 0; run_sel = '0;
    start1 = 1'b0; gate_sel1 = 3'b100;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {a, b, c, busy, done, pass, err_cnt, err_vec}, 18'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle hold: one pattern per cycle on the second instance.
    begin
      int nb, bad, cyc;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      nb = 0; bad = 0; cyc = 0;
      while (!done1 && cyc < 50) begin
        if (busy1) begin
          if ({a1, b1, c1} != 3'(nb)) bad++;
          nb++;
        end
        @(posedge clk); #1;
        cyc++;
      end
      check("h1_done", {31'd0, done1}, 32'd1);
      check("h1_busy_cycles", nb, 8);
      check("h1_patterns", bad, 0);
      check("h1_result", {err_vec1, err_cnt1, pass1}, {8'h00, 4'd0, 1'b1});
    end

    foreach (tbl[i]) run_vec(tbl[i]);

    repeat (3) @(posedge clk);
    #1;
    check("done_hold_stable", {done, err_vec, err_cnt, pass}, {1'b1, 8'h00, 4'd0, 1'b1});

    // Reset mid-run at pattern 3 after three recorded failures.
    begin
      int cyc;
      run_sel = 3'b001; mode = 0; gate_sel = 3'b001;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while ({a, b, c} != 3'd3 && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("reached_pattern3", {a, b, c, busy, err_cnt}, {3'd3, 1'b1, 4'd3});
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrun_reset", {a, b, c, busy, done, pass, err_cnt, err_vec}, 18'd0);
      @(posedge clk); #1;
      check("stays_idle", {a, b, c, busy, done, pass, err_cnt, err_vec}, 18'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_vector_seq.md
Name: gate_vector_seq

Overview:
- Sequential stimulus and check stage that sits directly upstream of a 3-input logic gate under test.
- Drives the gate's a/b/c inputs through all 8 patterns, from 3'b000 to 3'b111 with a as the MSB.
- Holds each pattern for a programmable number of cycles, then samples the gate output and compares it against the expected value for the selected gate function.
- Accumulates a per-pattern error bitmap and an error count, then reports done and pass.

Parameters:
- HOLD_CYCLES, default 10: cycles each pattern is held. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin a run. Sampled only in IDLE or DONE.
- gate_sel  input  3  expected function, latched on an accepted start: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110/111 reserved.
- dut_out  input  1  output of the gate under test, combinational from a/b/c.
- a  output  1  gate input a (pattern bit 2).
- b  output  1  gate input b (pattern bit 1).
- c  output  1  gate input c (pattern bit 0).
- busy  output  1  high while in the APPLY state.
- done  output  1  high in the DONE state.
- pass  output  1  valid when done is high; equals (err_cnt == 0) and no configuration error.
- err_cnt  output  4  number of failing patterns, 0..8.
- err_vec  output  8  bit i set means pattern i failed.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = IDLE; a = b = c = 0; busy, done, pass = 0; err_cnt = 0; err_vec = 0; hold counter and pattern index = 0.
  - Reset has priority over everything, including mid-run; no partial results survive.
- States: IDLE, APPLY, DONE.
- IDLE:
  - Outputs a/b/c = 0.
  - start = 1 latches gate_sel and clears err_cnt/err_vec.
  - Valid code -> APPLY next cycle with pattern index 0 and hold counter 0.
  - Reserved code -> DONE next cycle with err_vec = 8'hFF, err_cnt = 8, pass = 0.
- APPLY:
  - {a,b,c} = pattern index; busy = 1.
  - Hold counter increments each cycle.
  - When the counter equals HOLD_CYCLES-1:
    - dut_out is sampled at that edge and compared with expected f(a,b,c).
    - On mismatch, set err_vec[index] and increment err_cnt.
    - If index = 7 -> DONE; otherwise index+1 and counter cleared.
  - Timing:
    - Each pattern is driven for exactly HOLD_CYCLES cycles.
    - busy is high for exactly 8*HOLD_CYCLES cycles.
    - done rises on the cycle after the last sample.
  - With HOLD_CYCLES = 1, one pattern per cycle; dut_out is sampled in the same cycle the pattern is driven, which is legal because the gate is combinational.
- DONE:
  - a/b/c = 0; done = 1.
  - pass = (err_cnt == 0) and gate_sel is not reserved.
  - err_cnt, err_vec and pass hold stable until the next accepted start or reset.
  - start = 1 restarts exactly as from IDLE, with counts cleared.
- start while busy is ignored; the run is unaffected.
- gate_sel changes after start is accepted have no effect on the current run.
- err_cnt saturates naturally at 8 (at most 8 patterns); no wrap.

Test Plan:
- gate_sel = 001, dut_out = ~(a&b&c), HOLD_CYCLES = 10, start pulse -> busy high for 80 cycles, each pattern held 10 cycles, then done = 1, pass = 1, err_cnt = 0, err_vec = 8'h00.
- gate_sel = 000, dut_out tied 0 -> err_vec = 8'h80, err_cnt = 1, pass = 0.
- gate_sel = 001, dut_out tied 0 -> err_vec = 8'h7F, err_cnt = 7, pass = 0.
- gate_sel = 110 -> done one cycle after start, busy never high, err_vec = 8'hFF, err_cnt = 8, pass = 0.
- Reset mid-run: rst_n low for one edge while pattern index = 3 -> next cycle IDLE, all outputs 0. A start pulse during busy produces no change. A start in DONE restarts the run with cleared counts.
- HOLD_CYCLES = 1, gate_sel = 100, dut_out = a^b^c -> busy for 8 cycles, {a,b,c} steps 000..111 one per cycle, pass = 1.
